// File: rtl/sfp_event_tx_if.sv
// Transmit link bus: 16-bit word plus per-byte K-character flags.
// Registered at the source, no backpressure; the link consumes one word every clk_i.
interface sfp_event_tx_if;
  logic [15:0] txdata;
  logic [1:0]  txcharisk;

  modport master (output txdata, output txcharisk);
  modport slave  (input  txdata, input  txcharisk);
endinterface

// File: rtl/sfp_event_tx.sv
// Event-link transmitter: seconds sequence > heartbeat > user events > comma/idle on the low byte.
// One word per clk_i and no backpressure; seconds codes start 1 edge after pps_i, event codes 2 edges after event_i.
module sfp_event_tx #(
  parameter int unsigned HB_PERIOD = 125000000,
  parameter int          EVENTS    = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [7:0]        dbus_i,
  input  logic [EVENTS-1:0] event_i,
  input  logic [31:0]       EVENT1,
  input  logic [31:0]       EVENT2,
  input  logic [31:0]       EVENT3,
  input  logic [31:0]       EVENT4,
  input  logic [31:0]       utime_i,
  input  logic              pps_i,
  sfp_event_tx_if.master    tx_o,
  output logic [EVENTS-1:0] event_drop_o,
  output logic              pps_overrun_o
);

  localparam logic [31:0] HB_LAST = 32'(HB_PERIOD - 1);
  localparam int          IDXW    = (EVENTS > 1) ? $clog2(EVENTS) : 1;

  localparam logic [7:0] K_COMMA  = 8'hBC;
  localparam logic [7:0] C_SEC0   = 8'h70;
  localparam logic [7:0] C_SEC1   = 8'h71;
  localparam logic [7:0] C_HBEAT  = 8'h7A;
  localparam logic [7:0] C_RSTEVT = 8'h7D;

  typedef enum logic [1:0] {IDLE, SECS, RSTEVT} state_e;

  state_e            state_q, state_d;
  logic [4:0]        bit_idx_q, bit_idx_d;
  logic [31:0]       utime_q, utime_d;
  logic [31:0]       hb_cnt_q, hb_cnt_d;
  logic              hb_pend_q, hb_pend_d;
  logic [EVENTS-1:0] event_q, event_d;
  logic [EVENTS-1:0] pending_q, pending_d;
  logic [EVENTS-1:0] drop_q, drop_d;
  logic              phase_q, phase_d;
  logic              ovr_q, ovr_d;
  logic [15:0]       txdata_q, txdata_d;
  logic [1:0]        txk_q, txk_d;

  logic [7:0]        code_w [4];
  logic [7:0]        fsm_code;
  logic              hb_wrap;
  logic              hb_emit;
  logic              sel_found;
  logic [IDXW-1:0]   sel_idx;
  logic [EVENTS-1:0] serve;
  logic [7:0]        lo_byte;
  logic              lo_k;

  // Only the low byte of each event code register carries meaning.
  logic unused_code_bits;
  assign unused_code_bits = ^{EVENT1[31:8], EVENT2[31:8], EVENT3[31:8], EVENT4[31:8]};

  assign code_w[0] = EVENT1[7:0];
  assign code_w[1] = EVENT2[7:0];
  assign code_w[2] = EVENT3[7:0];
  assign code_w[3] = EVENT4[7:0];

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    utime_d   = utime_q;
    ovr_d     = ovr_q;
    event_d   = event_i;
    phase_d   = ~phase_q;
    fsm_code  = 8'h00;
    hb_emit   = 1'b0;
    serve     = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    lo_byte   = phase_q ? K_COMMA : 8'h00;
    lo_k      = phase_q;

    hb_wrap  = (hb_cnt_q == HB_LAST);
    hb_cnt_d = hb_wrap ? 32'd0 : hb_cnt_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (pps_i) begin
          utime_d   = utime_i;
          bit_idx_d = 5'd31;
          state_d   = SECS;
        end
      end
      SECS: begin
        fsm_code = utime_q[bit_idx_q] ? C_SEC1 : C_SEC0;
        if (bit_idx_q == 5'd0) state_d = RSTEVT;
        else                   bit_idx_d = bit_idx_q - 5'd1;
        if (pps_i) ovr_d = 1'b1;
      end
      RSTEVT: begin
        fsm_code = C_RSTEVT;
        state_d  = IDLE;
        if (pps_i) ovr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Scan downwards so the lowest pending channel wins.
    for (int i = EVENTS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
      end
    end

    if (state_q != IDLE) begin
      lo_byte = fsm_code;
      lo_k    = 1'b0;
    end else if (hb_pend_q) begin
      lo_byte = C_HBEAT;
      lo_k    = 1'b0;
      hb_emit = 1'b1;
    end else if (sel_found) begin
      serve[sel_idx] = 1'b1;
      // A zero code just retires the request; the slot falls through to idle.
      if (code_w[sel_idx] != 8'h00) begin
        lo_byte = code_w[sel_idx];
        lo_k    = 1'b0;
      end
    end

    hb_pend_d = (hb_pend_q & ~hb_emit) | hb_wrap;
    pending_d = (pending_q & ~serve) | event_q;
    drop_d    = event_q & pending_q & ~serve;
    txdata_d  = {dbus_i, lo_byte};
    txk_d     = {1'b0, lo_k};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      bit_idx_q <= 5'd0;
      utime_q   <= 32'd0;
      hb_cnt_q  <= 32'd0;
      hb_pend_q <= 1'b0;
      event_q   <= '0;
      pending_q <= '0;
      drop_q    <= '0;
      phase_q   <= 1'b0;
      ovr_q     <= 1'b0;
      txdata_q  <= 16'h0000;
      txk_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      utime_q   <= utime_d;
      hb_cnt_q  <= hb_cnt_d;
      hb_pend_q <= hb_pend_d;
      event_q   <= event_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      phase_q   <= phase_d;
      ovr_q     <= ovr_d;
      txdata_q  <= txdata_d;
      txk_q     <= txk_d;
    end
  end

  assign tx_o.txdata    = txdata_q;
  assign tx_o.txcharisk = txk_q;
  assign event_drop_o   = drop_q;
  assign pps_overrun_o  = ovr_q;

endmodule

// File: tb/tb_sfp_event_tx.sv
// Directed bench for sfp_event_tx with HB_PERIOD=64; cyc counts edges since the last reset release.
module tb_sfp_event_tx;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  dbus_i;
  logic [3:0]  event_i;
  logic [31:0] EVENT1, EVENT2, EVENT3, EVENT4;
  logic [31:0] utime_i;
  logic        pps_i;
  logic [3:0]  event_drop_o;
  logic        pps_overrun_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] evt_exp [4] = '{8'h7C, 8'h7B, 8'h7A, 8'h80};

  sfp_event_tx_if tx_if ();

  sfp_event_tx #(.HB_PERIOD(64), .EVENTS(4)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .dbus_i        (dbus_i),
    .event_i       (event_i),
    .EVENT1        (EVENT1),
    .EVENT2        (EVENT2),
    .EVENT3        (EVENT3),
    .EVENT4        (EVENT4),
    .utime_i       (utime_i),
    .pps_i         (pps_i),
    .tx_o          (tx_if),
    .event_drop_o  (event_drop_o),
    .pps_overrun_o (pps_overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Comma phase restarts at 0 on reset release: odd edges carry 0x00, even edges 0xBC/K.
  task automatic chk_idle(input string tag);
    chk(tag, {24'h0, tx_if.txdata[7:0]}, (cyc % 2 == 1) ? 32'h00 : 32'hBC);
    chk({tag, "_k"}, {30'h0, tx_if.txcharisk}, (cyc % 2 == 1) ? 32'h0 : 32'h1);
  endtask

  // Expected code for word w (1..33) of the seconds sequence for utime 0xA5000001.
  function automatic logic [7:0] secs_exp(input int w);
    case (w)
      1, 3, 6, 8, 32: return 8'h71;
      33:             return 8'h7D;
      default:        return 8'h70;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    dbus_i  = 8'h5A;
    event_i = 4'h0;
    EVENT1  = 32'hFFFF_FF7C;
    EVENT2  = 32'h0000_007B;
    EVENT3  = 32'h0000_007A;
    EVENT4  = 32'h0000_0080;
    utime_i = 32'hA500_0001;
    pps_i   = 1'b0;

    repeat (3) tick();
    chk("rst_txdata",  {16'h0, tx_if.txdata}, 32'h0);
    chk("rst_k",       {30'h0, tx_if.txcharisk}, 32'h0);
    chk("rst_drop",    {28'h0, event_drop_o}, 32'h0);
    chk("rst_overrun", {31'h0, pps_overrun_o}, 32'h0);

    reset_i = 1'b0;
    cyc = 0;
    tick();
    chk("rel1_lo", {24'h0, tx_if.txdata[7:0]}, 32'h00);
    chk("rel1_k",  {30'h0, tx_if.txcharisk}, 32'h0);
    tick();
    chk("rel2_lo", {24'h0, tx_if.txdata[7:0]}, 32'hBC);
    chk("rel2_k",  {30'h0, tx_if.txcharisk}, 32'h1);
    chk("dbus_hi", {24'h0, tx_if.txdata[15:8]}, 32'h5A);

    // All four channels requested together, sampled at edge 3, codes at edges 5..8.
    event_i = 4'hF;
    tick();
    event_i = 4'h0;
    chk_idle("evt_wait3");
    tick();
    chk_idle("evt_wait4");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("evt_code", {24'h0, tx_if.txdata[7:0]}, {24'h0, evt_exp[i]});
      chk("evt_k",    {30'h0, tx_if.txcharisk}, 32'h0);
      chk("evt_drop", {28'h0, event_drop_o}, 32'h0);
    end
    tick();
    chk_idle("evt_done");

    // Counter wraps at edges 64 and 128, heartbeat words at 65 and 129.
    run_to(64);
    chk_idle("hb1_pre");
    tick();
    chk("hb1",   {24'h0, tx_if.txdata[7:0]}, 32'h7A);
    chk("hb1_k", {30'h0, tx_if.txcharisk}, 32'h0);
    run_to(128);
    chk_idle("hb2_pre");
    tick();
    chk("hb2", {24'h0, tx_if.txdata[7:0]}, 32'h7A);

    // Seconds sequence: pps sampled at edge 131, words at edges 132..164.
    run_to(130);
    pps_i = 1'b1;
    tick();
    pps_i = 1'b0;
    chk_idle("pps_edge");
    for (int w = 1; w <= 33; w++) begin
      tick();
      chk("secs", {24'h0, tx_if.txdata[7:0]}, {24'h0, secs_exp(w)});
      if (w == 6) chk("dbus_hi_secs", {24'h0, tx_if.txdata[15:8]}, 32'hC3);
      if (w == 5) dbus_i = 8'hC3;
    end
    tick();
    chk_idle("secs_after");
    chk("no_overrun", {31'h0, pps_overrun_o}, 32'h0);

    // Sequence at edges 241..273 swallows the wrap at 256; event 0 requested twice while busy.
    run_to(239);
    pps_i = 1'b1;
    tick();
    pps_i = 1'b0;
    run_to(249);
    event_i = 4'h1;
    tick();
    tick();
    event_i = 4'h0;
    chk("drop_251", {28'h0, event_drop_o}, 32'h0);
    tick();
    chk("drop_252", {28'h0, event_drop_o}, 32'h1);
    tick();
    chk("drop_253", {28'h0, event_drop_o}, 32'h0);
    run_to(272);
    chk("coll_bit0", {24'h0, tx_if.txdata[7:0]}, 32'h71);
    tick();
    chk("coll_7d", {24'h0, tx_if.txdata[7:0]}, 32'h7D);
    tick();
    chk("hb_after_7d", {24'h0, tx_if.txdata[7:0]}, 32'h7A);
    tick();
    chk("evt_after_hb", {24'h0, tx_if.txdata[7:0]}, 32'h7C);
    tick();
    chk_idle("evt_once_a");
    tick();
    chk_idle("evt_once_b");

    // Overrun at word 10, then reset at word 20.
    run_to(299);
    pps_i = 1'b1;
    tick();
    pps_i = 1'b0;
    run_to(309);
    chk("ovr_before", {31'h0, pps_overrun_o}, 32'h0);
    pps_i = 1'b1;
    tick();
    pps_i = 1'b0;
    chk("ovr_set", {31'h0, pps_overrun_o}, 32'h1);
    chk("ovr_word10", {24'h0, tx_if.txdata[7:0]}, {24'h0, secs_exp(10)});
    for (int w = 11; w <= 19; w++) begin
      tick();
      chk("ovr_cont", {24'h0, tx_if.txdata[7:0]}, {24'h0, secs_exp(w)});
    end
    chk("ovr_sticky", {31'h0, pps_overrun_o}, 32'h1);
    reset_i = 1'b1;
    tick();
    chk("abort_txdata",  {16'h0, tx_if.txdata}, 32'h0);
    chk("abort_k",       {30'h0, tx_if.txcharisk}, 32'h0);
    chk("abort_overrun", {31'h0, pps_overrun_o}, 32'h0);

    reset_i = 1'b0;
    cyc = 0;
    EVENT2 = 32'h0;
    tick();
    chk("rerel1_lo", {24'h0, tx_if.txdata[7:0]}, 32'h00);
    tick();
    chk("rerel2_lo", {24'h0, tx_if.txdata[7:0]}, 32'hBC);
    chk("rerel2_k",  {30'h0, tx_if.txcharisk}, 32'h1);

    // Channel 2 has code 0x00: it retires silently after channel 1 is sent.
    event_i = 4'h3;
    tick();
    event_i = 4'h0;
    chk_idle("zero_wait3");
    tick();
    chk_idle("zero_wait4");
    tick();
    chk("zero_ch1", {24'h0, tx_if.txdata[7:0]}, 32'h7C);
    tick();
    chk_idle("zero_ch2");
    tick();
    chk_idle("zero_after");
    chk("zero_drop", {28'h0, event_drop_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
